fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the MIPS core, directly upstream of the main controller and decoder. It owns the program counter and fetches 32-bit words from a variable-latency instruction memory over a req/ack handshake. It holds the fetched word stable, with a valid flag, for the controller and datapath, whose `op` comes from `instr[31:26]`. When the datapath retires the instruction, it computes the next PC from the controller's `pc_src` and `jump` decisions.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC after reset. Must be word-aligned; elaboration fails otherwise.
- `MAX_WAIT`, default 15: number of ack-less request cycles tolerated before a fetch error. Must be ≥ 1.

- `clk`  in  1  — the single clock.
- `reset`  in  1  — asynchronous, active-high.
- `imem_req`  out  1  — fetch request to instruction memory.
- `imem_addr`  out  32  — fetch address; always equals `pc`.
- `imem_ack`  in  1  — memory has returned `imem_rdata` this cycle.
- `imem_rdata`  in  32  — instruction word; sampled only when ack is accepted.
- `instr`  out  32  — held instruction; `op` = `instr[31:26]`.
- `instr_valid`  out  1  — `instr` is valid for decode/execute.
- `pc`  out  32  — address of the current instruction.
- `pc_plus4`  out  32  — `pc` + 4, modulo 2^32.
- `retire`  in  1  — datapath finished the current instruction; next-PC inputs are valid.
- `pc_src`  in  1  — from controller: take the branch (branch & zero).
- `jump`  in  1  — from controller: J-type jump.
- `sign_imm`  in  32  — sign-extended immediate of the current instruction.
- `fetch_err`  out  1  — sticky fetch timeout.

## Operation
- States: `S_IDLE`, `S_REQ`, `S_HOLD`, `S_ERR`.
- Reset state is `S_IDLE`. Reset values:
  - `pc` = `RESET_PC`.
  - `instr` = 0.
  - `instr_valid` = 0, `imem_req` = 0, `fetch_err` = 0.
  - wait counter = 0.
- `S_IDLE`: always goes to `S_REQ` on the next edge.
- `S_REQ`:
  - Outputs: `imem_req` = 1, `imem_addr` = `pc`.
  - On `imem_ack`: latch `imem_rdata` into `instr`, clear the counter, go to `S_HOLD`.
  - Else if counter == `MAX_WAIT`: go to `S_ERR`.
  - Else: increment the counter.
  - If ack arrives in the same cycle that counter == `MAX_WAIT`, ack wins. `MAX_WAIT`+1 request cycles are allowed in total.
- `S_HOLD`:
  - Outputs: `instr_valid` = 1, `imem_req` = 0.
  - On `retire`: `pc` ← next_pc, go to `S_REQ`.
- `S_ERR`: `fetch_err` = 1, `imem_req` = 0, `instr_valid` = 0. Leaves only on reset.
- next_pc priority:
  - `jump`: {`pc_plus4[31:28]`, `instr[25:0]`, 2'b00}.
  - else `pc_src`: `pc_plus4` + (`sign_imm` << 2), truncated to 32 bits.
  - else `pc_plus4`.
- Arithmetic wraps modulo 2^32. Word alignment is preserved by construction.
- Ignored inputs:
  - `imem_ack` outside `S_REQ`.
  - `retire` outside `S_HOLD`.
  - `pc_src`, `jump` and `sign_imm` when `retire` = 0.
- `instr` and `pc` are stable throughout `S_HOLD`.
- Counter width is $clog2(`MAX_WAIT`+1).

## Timing
- Reset deasserted before edge 0: `S_REQ` after edge 0, `imem_req` high in cycle 1.
- Zero-wait ack (same cycle as `imem_req`): `instr_valid` high the next cycle.
- Fetch latency is 1 + N cycles for N wait cycles.
- `retire` sampled at edge t:
  - `pc` updated and `imem_req` high after edge t.
  - `instr_valid` low in that same cycle.
- Peak throughput is one instruction per 2 cycles.
- Asserting `reset` in any state forces all outputs to reset values immediately, without waiting for a clock. An outstanding memory request is abandoned, and any late ack is ignored because the unit is in `S_IDLE`.
- All outputs are registered or decoded from state only. No combinational path from `imem_ack`/`retire` to `imem_req`/`instr_valid`.

## Structure
- Shared package `mips_pkg`:
  - `fetch_state_t` enum.
  - Constants `WORD_BYTES` = 4, `OP_MSB` = 31, `OP_LSB` = 26, `JTARGET_W` = 26.
- Sub-module `next_pc_logic`: combinational next-PC mux, inputs `pc_plus4`, `instr[25:0]`, `sign_imm`, `pc_src`, `jump`.
- FSM, counter and registers stay in `fetch_unit`.

## Test plan
- **Reset and sequential fetch:** reset, `RESET_PC` = 0, memory acks with zero wait, `retire` pulsed each `S_HOLD` → `imem_addr` sequence 0x0, 0x4, 0x8; `instr_valid` alternates low/high; first `instr` = word at 0x0.
- **Branch:** at `pc` = 0x100, `retire` with `pc_src` = 1, `sign_imm` = 32'hFFFF_FFFE → next `imem_addr` = 0x0FC. `jump` = 1 and `pc_src` = 1 together → jump target wins.
- **Jump:** at `pc` = 0x0040_0000, `instr` = 32'h0810_0004 (j), `jump` = 1 → next `pc` = 0x0040_0010.
- **Wait states and timeout:** `MAX_WAIT` = 3.
  - Ack after 3 wait cycles → accepted, no error.
  - No ack for 4 request cycles → `fetch_err` = 1 and `imem_req` = 0 from the 5th cycle; both stay until reset.
- **Wrap-around:** `pc` = 32'hFFFF_FFFC, plain retire → `pc` = 0x0.
- **Reset mid-operation:** assert `reset` while in `S_REQ` with `imem_req` high → `imem_req` low before the next edge; a subsequent ack is ignored; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg -- shared definitions for the MIPS core front end.
//   fetch_state_t : state encoding of the instruction fetch FSM
//   WORD_BYTES    : instruction size in bytes (PC increment)
//   OP_MSB/OP_LSB : opcode field position inside an instruction word
//   JTARGET_W     : width of the J-type jump target field
package mips_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } fetch_state_t;

  localparam int WORD_BYTES = 4;
  localparam int OP_MSB     = 31;
  localparam int OP_LSB     = 26;
  localparam int JTARGET_W  = 26;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if -- instruction memory req/ack handshake.
//   req   : fetch request (master -> memory)
//   addr  : fetch address, word aligned (master -> memory)
//   ack   : memory returns rdata this cycle (memory -> master)
//   rdata : 32-bit instruction word (memory -> master)
// Modports: master = fetch unit side, slave = memory side.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_unit_next_pc_logic.sv
// next_pc_logic -- combinational next-PC selection for the fetch unit.
//   pc_plus4 : address of the sequential successor
//   jtarget  : J-type target field, instr[25:0]
//   sign_imm : sign-extended branch immediate (word offset)
//   pc_src   : take the branch
//   jump     : take the J-type jump (has priority over pc_src)
//   next_pc  : selected next program counter
module next_pc_logic
  import mips_pkg::*;
(
  input  logic [31:0]          pc_plus4,
  input  logic [JTARGET_W-1:0] jtarget,
  input  logic [31:0]          sign_imm,
  input  logic                 pc_src,
  input  logic                 jump,
  output logic [31:0]          next_pc
);

  logic [31:0] jump_pc;
  logic [31:0] branch_pc;

  // Jump keeps the 256 MB region of the delay-slot address.
  assign jump_pc   = {pc_plus4[31:28], jtarget, 2'b00};
  // Shift drops sign_imm[31:30]; sum wraps modulo 2^32.
  assign branch_pc = pc_plus4 + (sign_imm << 2);

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_pc;
    end else if (pc_src) begin
      next_pc = branch_pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage of the MIPS core.
// Owns the PC, fetches words over a req/ack handshake with a bounded
// wait, holds the fetched word for decode until the datapath retires it,
// then advances the PC using the controller's pc_src/jump decisions.
// Parameters:
//   RESET_PC : PC after reset (word aligned)
//   MAX_WAIT : ack-less request cycles tolerated before fetch_err (>= 1)
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   imem        : instruction memory handshake (master side)
//   instr       : held instruction word, op = instr[31:26]
//   instr_valid : instr valid for decode/execute
//   pc, pc_plus4: current instruction address and its successor
//   retire      : current instruction done, next-PC inputs valid
//   pc_src, jump, sign_imm : next-PC controls from controller/datapath
//   fetch_err   : sticky fetch timeout
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                reset,
  fetch_unit_if.master        imem,
  output logic [31:0]         instr,
  output logic                instr_valid,
  output logic [31:0]         pc,
  output logic [31:0]         pc_plus4,
  input  logic                retire,
  input  logic                pc_src,
  input  logic                jump,
  input  logic [31:0]         sign_imm,
  output logic                fetch_err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  generate
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
      $error("fetch_unit: RESET_PC must be word aligned");
    end
    if (MAX_WAIT < 1) begin : g_bad_max_wait
      $error("fetch_unit: MAX_WAIT must be at least 1");
    end
  endgenerate

  fetch_state_t     state;
  logic [31:0]      pc_q;
  logic [31:0]      instr_q;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      next_pc;

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'(WORD_BYTES);
  assign instr    = instr_q;

  // Handshake and status outputs decode from state only, so neither
  // ack nor retire has a combinational path to req/instr_valid.
  assign imem.req    = (state == S_REQ);
  assign imem.addr   = pc_q;
  assign instr_valid = (state == S_HOLD);
  assign fetch_err   = (state == S_ERR);

  next_pc_logic u_next_pc (
    .pc_plus4 (pc_plus4),
    .jtarget  (instr_q[JTARGET_W-1:0]),
    .sign_imm (sign_imm),
    .pc_src   (pc_src),
    .jump     (jump),
    .next_pc  (next_pc)
  );

  // In S_REQ an ack takes priority over the timeout check, so a total of
  // MAX_WAIT+1 request cycles is allowed. S_ERR only exits via reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= 32'h0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_REQ;
        end
        S_REQ: begin
          if (imem.ack) begin
            instr_q  <= imem.rdata;
            wait_cnt <= '0;
            state    <= S_HOLD;
          end else if (wait_cnt == CNT_MAX) begin
            state <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (retire) begin
            pc_q  <= next_pc;
            state <= S_REQ;
          end
        end
        S_ERR: begin
          state <= S_ERR;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed self-checking bench for fetch_unit.
// DUT is built with RESET_PC = 0 and MAX_WAIT = 3. Inputs change and
// outputs are checked 1 ns after each rising edge.
module tb_fetch_unit;
  import mips_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        retire;
  logic        pc_src;
  logic        jump;
  logic [31:0] sign_imm;
  logic        fetch_err;

  int vectorCount;
  int missCount;

  fetch_unit_if imem ();

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .MAX_WAIT (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (imem),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .retire      (retire),
    .pc_src      (pc_src),
    .jump        (jump),
    .sign_imm    (sign_imm),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the first S_REQ cycle; acks after 'waits' empty cycles.
  task automatic applyStimulus(input logic [31:0] word, input int waits);
    for (int i = 0; i < waits; i++) begin
      step();
    end
    imem.ack   = 1'b1;
    imem.rdata = word;
    step();
    imem.ack   = 1'b0;
    imem.rdata = 32'hDEAD_BEEF;
  endtask

  task automatic retireWith(input logic src, input logic jmp, input logic [31:0] imm);
    retire   = 1'b1;
    pc_src   = src;
    jump     = jmp;
    sign_imm = imm;
    step();
    retire   = 1'b0;
    pc_src   = 1'b0;
    jump     = 1'b0;
    sign_imm = 32'h0;
  endtask

  initial begin
    vectorCount = 0;
    missCount   = 0;
    reset       = 1'b1;
    retire      = 1'b0;
    pc_src      = 1'b0;
    jump        = 1'b0;
    sign_imm    = 32'h0;
    imem.ack    = 1'b0;
    imem.rdata  = 32'h0;
    #2;
    checkOutput("rst_req",   32'(imem.req), 32'h0);
    checkOutput("rst_valid", 32'(instr_valid), 32'h0);
    checkOutput("rst_err",   32'(fetch_err), 32'h0);
    checkOutput("rst_pc",    pc, 32'h0);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_pc4",   pc_plus4, 32'h4);
    step();
    reset = 1'b0;

    // Sequential fetch, zero wait.
    step();
    checkOutput("seq0_req",   32'(imem.req), 32'h1);
    checkOutput("seq0_addr",  imem.addr, 32'h0);
    checkOutput("seq0_valid", 32'(instr_valid), 32'h0);
    applyStimulus(32'h2008_0001, 0);
    checkOutput("seq0_hvalid", 32'(instr_valid), 32'h1);
    checkOutput("seq0_instr",  instr, 32'h2008_0001);
    checkOutput("seq0_hreq",   32'(imem.req), 32'h0);
    retireWith(1'b0, 1'b0, 32'h0);
    checkOutput("seq1_addr",  imem.addr, 32'h4);
    checkOutput("seq1_valid", 32'(instr_valid), 32'h0);
    checkOutput("seq1_req",   32'(imem.req), 32'h1);
    applyStimulus(32'h2009_0002, 0);
    checkOutput("seq1_instr", instr, 32'h2009_0002);
    retireWith(1'b0, 1'b0, 32'h0);
    checkOutput("seq2_addr", imem.addr, 32'h8);

    // Jump to 0x100.
    applyStimulus(32'h0800_0040, 0);
    retireWith(1'b0, 1'b1, 32'h0);
    checkOutput("j100_pc", pc, 32'h0000_0100);

    // Branch backwards: 0x104 + (-2 << 2) = 0xFC.
    applyStimulus(32'h1000_FFFE, 0);
    retireWith(1'b1, 1'b0, 32'hFFFF_FFFE);
    checkOutput("br_addr", imem.addr, 32'h0000_00FC);

    // jump and pc_src together: jump target wins.
    applyStimulus(32'h0810_0000, 0);
    retireWith(1'b1, 1'b1, 32'h0000_0005);
    checkOutput("jprio_pc", pc, 32'h0040_0000);

    // Jump from 0x0040_0000 with j 0x100004.
    applyStimulus(32'h0810_0004, 0);
    retireWith(1'b0, 1'b1, 32'h0);
    checkOutput("jump_pc", pc, 32'h0040_0010);

    // Three wait cycles, ack in the 4th request cycle.
    for (int i = 0; i < 3; i++) begin
      checkOutput("wait_req", 32'(imem.req), 32'h1);
      step();
    end
    checkOutput("wait_lastreq", 32'(imem.req), 32'h1);
    checkOutput("wait_noerr",   32'(fetch_err), 32'h0);
    imem.ack   = 1'b1;
    imem.rdata = 32'h1234_5678;
    step();
    imem.ack   = 1'b0;
    checkOutput("wait_valid", 32'(instr_valid), 32'h1);
    checkOutput("wait_instr", instr, 32'h1234_5678);
    checkOutput("wait_err",   32'(fetch_err), 32'h0);

    // Branch to 0xFFFF_FFFC, then wrap to 0.
    retireWith(1'b1, 1'b0, 32'hFFEF_FFFA);
    checkOutput("wrap_pc",  pc, 32'hFFFF_FFFC);
    checkOutput("wrap_pc4", pc_plus4, 32'h0);
    applyStimulus(32'h0000_0020, 0);
    retireWith(1'b0, 1'b0, 32'h0);
    checkOutput("wrap_next", imem.addr, 32'h0);

    // Timeout: four ack-less request cycles, error from the 5th.
    step();
    step();
    step();
    checkOutput("to_req4", 32'(imem.req), 32'h1);
    checkOutput("to_err4", 32'(fetch_err), 32'h0);
    step();
    checkOutput("to_err",   32'(fetch_err), 32'h1);
    checkOutput("to_req",   32'(imem.req), 32'h0);
    checkOutput("to_valid", 32'(instr_valid), 32'h0);
    imem.ack = 1'b1;
    retire   = 1'b1;
    step();
    step();
    imem.ack = 1'b0;
    retire   = 1'b0;
    checkOutput("to_sticky",  32'(fetch_err), 32'h1);
    checkOutput("to_stkreq",  32'(imem.req), 32'h0);

    // Reset clears the error immediately.
    reset = 1'b1;
    #1;
    checkOutput("rerr_err", 32'(fetch_err), 32'h0);
    checkOutput("rerr_req", 32'(imem.req), 32'h0);
    step();
    reset = 1'b0;
    step();
    applyStimulus(32'h2000_0000, 0);
    retireWith(1'b0, 1'b0, 32'h0);
    checkOutput("mid_pc4",  pc, 32'h4);

    // Reset while requesting; a late ack must be ignored.
    reset = 1'b1;
    #1;
    checkOutput("mid_req",  32'(imem.req), 32'h0);
    checkOutput("mid_pc",   pc, 32'h0);
    imem.ack   = 1'b1;
    imem.rdata = 32'hBAD0_BAD0;
    step();
    reset = 1'b0;
    step();
    checkOutput("mid_valid", 32'(instr_valid), 32'h0);
    checkOutput("mid_instr", instr, 32'h0);
    checkOutput("mid_addr",  imem.addr, 32'h0);
    imem.ack = 1'b0;
    applyStimulus(32'hACE0_0001, 1);
    checkOutput("mid_refetch", instr, 32'hACE0_0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
